// File: rtl/sample_pkg.sv
// Shared sample type, stage mode encoding and saturation helpers for the effect chain.
package sample_pkg;

    localparam int SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    // Wide enough for 2x, negation and the unsigned 8-bit tremolo product.
    typedef logic signed [SAMPLE_W+8:0] wide_t;

    localparam sample_t SAMPLE_MAX = sample_t'(2 ** (SAMPLE_W - 1) - 1);
    localparam sample_t SAMPLE_MIN = sample_t'(-(2 ** (SAMPLE_W - 1)));

    typedef enum logic [3:0] {
        BYPASS  = 4'd0,
        GAIN    = 4'd1,
        ATTEN   = 4'd2,
        CLIP    = 4'd3,
        INVERT  = 4'd4,
        TREMOLO = 4'd5
    } mode_t;

    function automatic wide_t widen(input sample_t x);
        return wide_t'(x);
    endfunction

    function automatic sample_t sat(input wide_t v);
        if (v > wide_t'(SAMPLE_MAX)) begin
            return SAMPLE_MAX;
        end
        if (v < wide_t'(SAMPLE_MIN)) begin
            return SAMPLE_MIN;
        end
        return v[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/eff_stage.sv
// One effect stage: mode mux, saturation, per-stage triangle LFO with divider,
// and a registered output that holds its value between valid samples.
module eff_stage
    import sample_pkg::*;
#(
    parameter int CLIP_LVL = 8192,
    parameter int LFO_DIV  = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] mode,
    input  sample_t    data_i,
    input  logic       vld_i,
    output sample_t    data_o,
    output logic       vld_o
);

    localparam int DIV_W = (LFO_DIV > 1) ? $clog2(LFO_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(LFO_DIV - 1);
    localparam wide_t CLIP_POS = wide_t'(CLIP_LVL);
    localparam wide_t CLIP_NEG = -CLIP_POS;

    mode_t            mode_eff;
    wide_t            x_w;
    wide_t            prod;
    sample_t          y;
    logic [7:0]       lfo;
    logic             lfo_up;
    logic [DIV_W-1:0] div;
    logic             lfo_run;

    // Disabled chain and unassigned encodings both collapse to bypass.
    always_comb begin
        mode_eff = BYPASS;
        if (en && (mode <= TREMOLO)) begin
            mode_eff = mode_t'(mode);
        end
    end

    assign x_w     = widen(data_i);
    assign prod    = x_w * wide_t'({1'b0, lfo});
    assign lfo_run = vld_i && (mode_eff == TREMOLO);

    always_comb begin
        y = data_i;
        case (mode_eff)
            GAIN:    y = sat(x_w <<< 1);
            ATTEN:   y = data_i >>> 1;
            CLIP:    y = sat((x_w > CLIP_POS) ? CLIP_POS :
                             ((x_w < CLIP_NEG) ? CLIP_NEG : x_w));
            INVERT:  y = sat(-x_w);
            TREMOLO: y = sat(prod >>> 8);
            default: y = data_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_o <= '0;
            vld_o  <= 1'b0;
            lfo    <= 8'd0;
            lfo_up <= 1'b1;
            div    <= '0;
        end else begin
            vld_o <= vld_i;
            if (vld_i) begin
                data_o <= y;
            end
            // The sample uses the current LFO value; the step lands on later samples.
            if (lfo_run) begin
                if (div == DIV_TC) begin
                    div <= '0;
                    if (lfo_up) begin
                        if (lfo == 8'd255) begin
                            lfo    <= 8'd254;
                            lfo_up <= 1'b0;
                        end else begin
                            lfo <= lfo + 8'd1;
                        end
                    end else begin
                        if (lfo == 8'd0) begin
                            lfo    <= 8'd1;
                            lfo_up <= 1'b1;
                        end else begin
                            lfo <= lfo - 8'd1;
                        end
                    end
                end else begin
                    div <= div + DIV_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/eff_chain.sv
// Cascade of NUM_STAGES registered effect stages driven by registered en/sel,
// giving a fixed NUM_STAGES-cycle latency from vld_i to vld_o.
module eff_chain
    import sample_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int CLIP_LVL   = 8192,
    parameter int LFO_DIV    = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] sel,
    input  sample_t     data_i,
    input  logic        vld_i,
    output sample_t     data_o,
    output logic        vld_o
);

    logic            en_q;
    logic [15:0]     sel_q;
    sample_t         data_s [NUM_STAGES+1];
    logic [NUM_STAGES:0] vld_s;

    always_ff @(posedge clk) begin
        if (!rst) begin
            en_q  <= 1'b0;
            sel_q <= '0;
        end else begin
            en_q  <= en;
            sel_q <= sel;
        end
    end

    assign data_s[0] = data_i;
    assign vld_s[0]  = vld_i;

    // Stages beyond NUM_STAGES are simply not built, so their sel fields go nowhere.
    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        eff_stage #(
            .CLIP_LVL (CLIP_LVL),
            .LFO_DIV  (LFO_DIV)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .en     (en_q),
            .mode   (sel_q[4*k +: 4]),
            .data_i (data_s[k]),
            .vld_i  (vld_s[k]),
            .data_o (data_s[k+1]),
            .vld_o  (vld_s[k+1])
        );
    end

    assign data_o = data_s[NUM_STAGES];
    assign vld_o  = vld_s[NUM_STAGES];

endmodule
